// File: rtl/mem_tbus_arb.sv
// Two-requester arbiter in front of the dcache tbus. Stores have priority, but a
// waiting load is guaranteed a grant after STARVE_MAX consecutive store grants.
module mem_tbus_arb #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int OPT_W      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_index,
  input  logic [DATA_W-1:0] ld_req_wdata,
  input  logic [DATA_W-1:0] ld_req_wmask,
  input  logic [OPT_W-1:0]  ld_req_optype,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              ld_resp_done,
  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [ADDR_W-1:0] st_req_index,
  input  logic [DATA_W-1:0] st_req_wdata,
  input  logic [DATA_W-1:0] st_req_wmask,
  input  logic [OPT_W-1:0]  st_req_optype,
  output logic              st_resp_done,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_req_index,
  output logic [DATA_W-1:0] dc_req_wdata,
  output logic [DATA_W-1:0] dc_req_wmask,
  output logic [OPT_W-1:0]  dc_req_optype,
  input  logic [DATA_W-1:0] dc_read_data,
  input  logic              dc_operation_done,
  output logic              arb_busy,
  output logic              arb_grant_ld
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_grant_ld;
  logic       w_grant_ld_nxt;
  logic [2:0] r_starve_cnt;
  logic [2:0] w_starve_nxt;

  logic w_sel_ld;
  logic w_req_valid;
  logic w_ld_flush;
  logic w_fire;
  logic w_dc_valid;
  logic w_ld_ready;
  logic w_st_ready;
  logic w_ld_done;
  logic w_st_done;

  // Winner selection: live arbitration in IDLE, locked grant otherwise.
  always_comb begin
    w_sel_ld = r_grant_ld;
    if (r_state == ST_IDLE) begin
      w_sel_ld = ld_req_valid && (!st_req_valid || (r_starve_cnt == STARVE_LIM));
    end else begin
      w_sel_ld = r_grant_ld;
    end
    w_req_valid = w_sel_ld ? ld_req_valid : st_req_valid;
    w_ld_flush  = flush && r_grant_ld && (r_state != ST_IDLE);
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_ld_nxt = r_grant_ld;
    w_fire         = 1'b0;
    w_dc_valid     = 1'b0;
    w_ld_ready     = 1'b0;
    w_st_ready     = 1'b0;
    w_ld_done      = 1'b0;
    w_st_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_valid) begin
          w_dc_valid     = 1'b1;
          w_fire         = dc_req_ready;
          w_ld_ready     = w_sel_ld && dc_req_ready;
          w_st_ready     = !w_sel_ld && dc_req_ready;
          w_grant_ld_nxt = w_sel_ld;
          w_state_nxt    = dc_req_ready ? ST_BUSY : ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_dc_valid = w_req_valid;
        w_fire     = w_req_valid && dc_req_ready;
        w_ld_ready = r_grant_ld && dc_req_ready;
        w_st_ready = !r_grant_ld && dc_req_ready;
        if (w_ld_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fire) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_BUSY: begin
        // A flush on a load-owned transaction swallows a coincident done.
        if (w_ld_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (dc_operation_done) begin
          w_ld_done   = r_grant_ld;
          w_st_done   = !r_grant_ld;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts store grants taken while a load is waiting.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_fire && w_sel_ld) begin
      w_starve_nxt = 3'd0;
    end else if (w_fire && ld_req_valid) begin
      w_starve_nxt = (r_starve_cnt >= STARVE_LIM) ? STARVE_LIM : (r_starve_cnt + 3'd1);
    end else if ((r_state == ST_IDLE) && !ld_req_valid) begin
      w_starve_nxt = 3'd0;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // State, grant and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant_ld   <= 1'b0;
      r_starve_cnt <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_ld   <= w_grant_ld_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Control outputs are forced low while reset_n is held.
  assign dc_req_valid  = reset_n & w_dc_valid;
  assign ld_req_ready  = reset_n & w_ld_ready;
  assign st_req_ready  = reset_n & w_st_ready;
  assign ld_resp_done  = reset_n & w_ld_done;
  assign st_resp_done  = reset_n & w_st_done;
  assign arb_busy      = reset_n & (r_state != ST_IDLE);
  assign arb_grant_ld  = reset_n & (r_state != ST_IDLE) & r_grant_ld;

  assign dc_req_index  = w_sel_ld ? ld_req_index  : st_req_index;
  assign dc_req_wdata  = w_sel_ld ? ld_req_wdata  : st_req_wdata;
  assign dc_req_wmask  = w_sel_ld ? ld_req_wmask  : st_req_wmask;
  assign dc_req_optype = w_sel_ld ? ld_req_optype : st_req_optype;
  assign ld_resp_data  = dc_read_data;

endmodule

// File: tb/tb_mem_tbus_arb.sv
// Bench for mem_tbus_arb: a vector table driven through a small dcache model with
// an expected-grant queue, plus directed sequences for starvation, flush and reset.
module tb_mem_tbus_arb;

  localparam logic [63:0] KLD = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] KST = 64'h5A5A_0F0F_5A5A_0F0F;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        ld_req_valid, ld_req_ready;
  logic [63:0] ld_req_index, ld_req_wdata, ld_req_wmask;
  logic [1:0]  ld_req_optype;
  logic [63:0] ld_resp_data;
  logic        ld_resp_done;
  logic        st_req_valid, st_req_ready;
  logic [63:0] st_req_index, st_req_wdata, st_req_wmask;
  logic [1:0]  st_req_optype;
  logic        st_resp_done;
  logic        dc_req_valid, dc_req_ready;
  logic [63:0] dc_req_index, dc_req_wdata, dc_req_wmask;
  logic [1:0]  dc_req_optype;
  logic [63:0] dc_read_data;
  logic        dc_operation_done;
  logic        arb_busy, arb_grant_ld;

  typedef struct {
    bit          ld_v;
    bit          st_v;
    logic [63:0] ld_idx;
    logic [63:0] st_idx;
    int          rdy_dly;
    int          done_dly;
    logic [63:0] rdata;
    bit          first_ld;
  } vec_t;

  typedef struct {
    bit          is_ld;
    logic [63:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [1:0]  opt;
  } exp_t;

  exp_t q[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_tbus_arb dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_index(ld_req_index), .ld_req_wdata(ld_req_wdata),
    .ld_req_wmask(ld_req_wmask), .ld_req_optype(ld_req_optype),
    .ld_resp_data(ld_resp_data), .ld_resp_done(ld_resp_done),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_index(st_req_index), .st_req_wdata(st_req_wdata),
    .st_req_wmask(st_req_wmask), .st_req_optype(st_req_optype),
    .st_resp_done(st_resp_done),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_index(dc_req_index), .dc_req_wdata(dc_req_wdata),
    .dc_req_wmask(dc_req_wmask), .dc_req_optype(dc_req_optype),
    .dc_read_data(dc_read_data), .dc_operation_done(dc_operation_done),
    .arb_busy(arb_busy), .arb_grant_ld(arb_grant_ld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  function automatic exp_t mk_exp(input bit is_ld, input logic [63:0] idx);
    exp_t e;
    e.is_ld = is_ld;
    e.idx   = idx;
    e.wdata = idx ^ (is_ld ? KLD : KST);
    e.wmask = ~idx;
    e.opt   = is_ld ? 2'd1 : 2'd2;
    return e;
  endfunction

  task automatic set_fields(input logic [63:0] li, input logic [63:0] si);
    ld_req_index = li; ld_req_wdata = li ^ KLD; ld_req_wmask = ~li; ld_req_optype = 2'd1;
    st_req_index = si; st_req_wdata = si ^ KST; st_req_wmask = ~si; st_req_optype = 2'd2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    flush = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
    dc_req_ready = 1'b0; dc_operation_done = 1'b0; dc_read_data = 64'd0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drives one vector through a dcache model; grants are checked against the queue.
  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   ld_p, st_p, own_ld;
    int   rdy_cnt, busy_cnt, cyc;
    ld_p = v.ld_v; st_p = v.st_v; own_ld = 1'b0;
    rdy_cnt = v.rdy_dly; busy_cnt = -1; cyc = 0;
    set_fields(v.ld_idx, v.st_idx);
    if (v.ld_v && v.st_v) begin
      q.push_back(mk_exp(v.first_ld, v.first_ld ? v.ld_idx : v.st_idx));
      q.push_back(mk_exp(!v.first_ld, v.first_ld ? v.st_idx : v.ld_idx));
    end else begin
      q.push_back(mk_exp(v.ld_v, v.ld_v ? v.ld_idx : v.st_idx));
    end
    while ((ld_p || st_p || busy_cnt >= 0) && cyc < 100) begin
      @(negedge clock);
      if (busy_cnt > 0) busy_cnt--;
      ld_req_valid = ld_p; st_req_valid = st_p;
      dc_req_ready = (rdy_cnt == 0);
      dc_operation_done = (busy_cnt == 0);
      dc_read_data = v.rdata;
      #1;
      chk("ld_done", ld_resp_done, (busy_cnt == 0) && own_ld);
      chk("st_done", st_resp_done, (busy_cnt == 0) && !own_ld);
      if (busy_cnt == 0) begin
        chk("bubble_vld", dc_req_valid, 1'b0);
        if (own_ld) chk("ld_data", ld_resp_data, v.rdata);
        busy_cnt = -1;
      end else if (busy_cnt > 0) begin
        chk("busy_vld", dc_req_valid, 1'b0);
        chk("busy_rdy", {ld_req_ready, st_req_ready}, 2'b00);
      end else if (dc_req_valid && q.size() > 0) begin
        e = q[0];
        chk("idx", dc_req_index, e.idx);
        chk("wdata", dc_req_wdata, e.wdata);
        chk("wmask", dc_req_wmask, e.wmask);
        chk("opt", dc_req_optype, e.opt);
        chk("ld_rdy", ld_req_ready, e.is_ld && dc_req_ready);
        chk("st_rdy", st_req_ready, !e.is_ld && dc_req_ready);
        if (dc_req_ready) begin
          void'(q.pop_front());
          own_ld = e.is_ld;
          if (e.is_ld) ld_p = 1'b0; else st_p = 1'b0;
          busy_cnt = v.done_dly;
          rdy_cnt = v.rdy_dly;
        end else if (rdy_cnt > 0) begin
          rdy_cnt--;
        end
      end else begin
        chk("req_vld", dc_req_valid, ld_p || st_p);
      end
      cyc++;
    end
    if (cyc >= 100) timeout_fail("vec_timeout");
    @(negedge clock);
    ld_req_valid = 1'b0; st_req_valid = 1'b0;
    dc_req_ready = 1'b0; dc_operation_done = 1'b0;
    q.delete();
  endtask

  initial begin
    int  nf;
    bit  fired_prev;
    bit  exp_g[6];
    vecs[0] = '{1'b1, 1'b0, 64'h0000_0000_0000_1000, 64'h0, 0, 3, 64'hDEAD_BEEF, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 64'h0, 64'h0000_0000_0000_2000, 0, 1, 64'h1234, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 64'h0000_0000_0000_3000, 64'h0000_0000_0000_3008, 0, 2, 64'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 64'hFFFF_0000_0000_0040, 64'h0000_FFFF_0000_0080, 2, 1, 64'h55AA, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 3, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 64'h0, 64'h0000_0000_0000_0001, 1, 4, 64'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 64'h0000_0000_0BAD_0000, 64'h0000_0000_0600_D000, 1, 1, 64'hBEEF_0000, 1'b0};
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state with requests and done already asserted.
    reset_n = 1'b0; flush = 1'b0;
    ld_req_valid = 1'b1; st_req_valid = 1'b1; dc_req_ready = 1'b1;
    dc_operation_done = 1'b1; dc_read_data = 64'd0;
    set_fields(64'h10, 64'h20);
    #2;
    chk("rst_dc_vld", dc_req_valid, 1'b0);
    chk("rst_rdy", {ld_req_ready, st_req_ready}, 2'b00);
    chk("rst_done", {ld_resp_done, st_resp_done}, 2'b00);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_grant", arb_grant_ld, 1'b0);
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Continuous stores with a waiting load: S,S,S,S,L then S again.
    do_reset();
    set_fields(64'h100, 64'h200);
    nf = 0; fired_prev = 1'b0;
    for (int c = 0; c < 40 && nf < 6; c++) begin
      @(negedge clock);
      ld_req_valid = 1'b1; st_req_valid = 1'b1; dc_req_ready = 1'b1;
      dc_operation_done = fired_prev;
      #1;
      fired_prev = dc_req_valid && dc_req_ready;
      if (fired_prev) begin
        chk("starve_grant", ld_req_ready, exp_g[nf]);
        nf++;
      end
    end
    if (nf < 6) timeout_fail("starve_timeout");

    // Flush with done on a load-owned BUSY; pending store granted after.
    do_reset();
    set_fields(64'hAAAA, 64'hBBBB);
    @(negedge clock); ld_req_valid = 1'b1; dc_req_ready = 1'b1; #1;
    chk("fl_ld_fire", ld_req_ready, 1'b1);
    @(negedge clock); ld_req_valid = 1'b0; st_req_valid = 1'b1; #1;
    chk("fl_busy_vld", dc_req_valid, 1'b0);
    chk("fl_busy_strdy", st_req_ready, 1'b0);
    @(negedge clock); flush = 1'b1; dc_operation_done = 1'b1; dc_read_data = 64'h77; #1;
    chk("fl_ld_done", ld_resp_done, 1'b0);
    chk("fl_st_done", st_resp_done, 1'b0);
    @(negedge clock); flush = 1'b0; dc_operation_done = 1'b0; #1;
    chk("fl_idle", arb_busy, 1'b0);
    chk("fl_st_grant", st_req_ready, 1'b1);
    chk("fl_st_idx", dc_req_index, 64'hBBBB);
    @(negedge clock); st_req_valid = 1'b0; #1;
    chk("fl_st_owner", {arb_busy, arb_grant_ld}, 2'b10);
    @(negedge clock); flush = 1'b1; dc_operation_done = 1'b1; #1;
    chk("fl_st_done_kept", st_resp_done, 1'b1);

    // Load locked in REQ while the dcache stalls and a store arrives.
    do_reset();
    set_fields(64'h1111, 64'h2222);
    @(negedge clock); ld_req_valid = 1'b1; dc_req_ready = 1'b0; #1;
    chk("req_vld", dc_req_valid, 1'b1);
    chk("req_ldrdy0", ld_req_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); st_req_valid = 1'b1; #1;
      chk("req_hold_idx", dc_req_index, 64'h1111);
      chk("req_hold_grant", arb_grant_ld, 1'b1);
      chk("req_strdy0", st_req_ready, 1'b0);
    end
    @(negedge clock); dc_req_ready = 1'b1; #1;
    chk("req_ld_fire", {ld_req_ready, st_req_ready}, 2'b10);
    chk("req_fire_wdata", dc_req_wdata, 64'h1111 ^ KLD);
    @(negedge clock); ld_req_valid = 1'b0; dc_req_ready = 1'b0; #1;
    chk("req_busy_vld", dc_req_valid, 1'b0);
    @(negedge clock); dc_operation_done = 1'b1; dc_read_data = 64'h9999; #1;
    chk("req_ld_done", {ld_resp_done, st_resp_done}, 2'b10);
    chk("req_ld_data", ld_resp_data, 64'h9999);
    @(negedge clock); dc_operation_done = 1'b0; dc_req_ready = 1'b1; #1;
    chk("req_next_st", st_req_ready, 1'b1);
    chk("req_next_idx", dc_req_index, 64'h2222);

    // Flush of a load still waiting in REQ.
    do_reset();
    @(negedge clock); ld_req_valid = 1'b1; dc_req_ready = 1'b0;
    @(negedge clock); flush = 1'b1; #1;
    chk("frq_busy", arb_busy, 1'b1);
    @(negedge clock); flush = 1'b0; ld_req_valid = 1'b0; #1;
    chk("frq_idle", arb_busy, 1'b0);
    chk("frq_vld", dc_req_valid, 1'b0);

    // Reset asserted in BUSY; done after release is ignored.
    do_reset();
    set_fields(64'h4444, 64'h5555);
    @(negedge clock); ld_req_valid = 1'b1; dc_req_ready = 1'b1;
    @(negedge clock); ld_req_valid = 1'b0; st_req_valid = 1'b1; #1;
    chk("rb_busy", arb_busy, 1'b1);
    reset_n = 1'b0; #1;
    chk("rb_outs", {dc_req_valid, ld_req_ready, st_req_ready, ld_resp_done,
                    st_resp_done, arb_busy, arb_grant_ld}, 7'd0);
    @(negedge clock); reset_n = 1'b1; st_req_valid = 1'b0; dc_req_ready = 1'b0;
    dc_operation_done = 1'b1; #1;
    chk("rb_no_done", {ld_resp_done, st_resp_done}, 2'b00);
    chk("rb_idle", arb_busy, 1'b0);
    @(negedge clock); dc_operation_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
